// File: rtl/axi_lite_apb_bridge_if.sv
// Bus bundle for the AXI4-Lite to APB3 bridge.
// Carries the AXI4-Lite AW/W/B/AR/R channels and the APB3 master signals.
//   slave  : bridge view. Takes AXI requests and APB slave replies, drives AXI
//            readies/responses and APB control.
//   master : agent view. Drives AXI requests and APB slave replies.
interface axi_lite_apb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;
  logic [ADDR_W-1:0]   PADDR;
  logic                PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [DATA_W-1:0]   PWDATA;
  logic                PREADY;
  logic [DATA_W-1:0]   PRDATA;
  logic                PSLVERR;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARVALID, RREADY, PREADY, PRDATA, PSLVERR,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARVALID, RREADY, PREADY, PRDATA, PSLVERR,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB3 master bridge.
// Serves one AXI read or write at a time as a single APB SETUP/ACCESS transfer,
// and returns the APB result on B or R. An ACCESS phase that sees no PREADY for
// TIMEOUT cycles is aborted with SLVERR.
// Ports:
//   ACLK    : clock, rising edge
//   ARESETn : synchronous active-low reset
//   bus     : AXI4-Lite slave channels plus APB3 master signals (slave modport)
//
// state  | meaning
// IDLE   | waiting for a request; the only state where readies can assert
// SETUP  | APB setup phase, PSEL=1 PENABLE=0
// ACCESS | APB access phase, waiting for PREADY or timeout
// WRESP  | BVALID held until BREADY
// RRESP  | RVALID held until RREADY
module axi_lite_apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic ACLK,
  input  logic ARESETn,
  axi_lite_apb_bridge_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WRESP, RRESP} state_t;

  state_t            state;
  logic              wr_first;
  logic [CNT_W-1:0]  cnt;

  logic              wr_pend;
  logic              rd_pend;
  logic              take_wr;
  logic              take_rd;
  logic              req_bad;
  logic [ADDR_W-1:0] req_addr;

  // Readies are decoded from the registered state so the handshake happens in
  // the same cycle the request is seen; they are forced low during reset.
  always_comb begin
    wr_pend  = bus.AWVALID && bus.WVALID;
    rd_pend  = bus.ARVALID;
    take_wr  = ARESETn && (state == IDLE) && wr_pend && (wr_first || !rd_pend);
    take_rd  = ARESETn && (state == IDLE) && rd_pend && !take_wr;
    req_addr = take_wr ? bus.AWADDR : bus.ARADDR;
    req_bad  = (req_addr[1:0] != 2'b00) ||
               (take_wr && (bus.WSTRB != {STRB_W{1'b1}}));
  end

  assign bus.AWREADY = take_wr;
  assign bus.WREADY  = take_wr;
  assign bus.ARREADY = take_rd;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= IDLE;
      wr_first    <= 1'b1;
      cnt         <= '0;
      bus.PADDR   <= '0;
      bus.PSEL    <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PWDATA  <= '0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= 2'b00;
      bus.RVALID  <= 1'b0;
      bus.RRESP   <= 2'b00;
      bus.RDATA   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_wr || take_rd) begin
            wr_first <= ~wr_first;
            if (req_bad) begin
              // Misaligned or partial-strobe request: answer without touching APB.
              if (take_wr) begin
                state      <= WRESP;
                bus.BVALID <= 1'b1;
                bus.BRESP  <= 2'b10;
              end else begin
                state      <= RRESP;
                bus.RVALID <= 1'b1;
                bus.RRESP  <= 2'b10;
                bus.RDATA  <= '0;
              end
            end else begin
              state      <= SETUP;
              bus.PSEL   <= 1'b1;
              bus.PADDR  <= req_addr;
              bus.PWRITE <= take_wr;
              if (take_wr) begin
                bus.PWDATA <= bus.WDATA;
              end
            end
          end
        end

        SETUP: begin
          state       <= ACCESS;
          bus.PENABLE <= 1'b1;
          cnt         <= '0;
        end

        ACCESS: begin
          if (bus.PREADY) begin
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            if (bus.PWRITE) begin
              state      <= WRESP;
              bus.BVALID <= 1'b1;
              bus.BRESP  <= bus.PSLVERR ? 2'b10 : 2'b00;
            end else begin
              state      <= RRESP;
              bus.RVALID <= 1'b1;
              bus.RRESP  <= bus.PSLVERR ? 2'b10 : 2'b00;
              bus.RDATA  <= bus.PRDATA;
            end
          end else if (cnt == CNT_LAST) begin
            // This is the TIMEOUT-th ACCESS cycle without PREADY: abort.
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            if (bus.PWRITE) begin
              state      <= WRESP;
              bus.BVALID <= 1'b1;
              bus.BRESP  <= 2'b10;
            end else begin
              state      <= RRESP;
              bus.RVALID <= 1'b1;
              bus.RRESP  <= 2'b10;
              bus.RDATA  <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WRESP: begin
          if (bus.BREADY) begin
            bus.BVALID <= 1'b0;
            state      <= IDLE;
          end
        end

        RRESP: begin
          if (bus.RREADY) begin
            bus.RVALID <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Self-checking bench for axi_lite_apb_bridge: a table of directed transfers,
// randomized transfers checked against a rule-level reference model, and hand
// sequences for arbitration and mid-transfer reset.
module tb_axi_lite_apb_bridge;

  localparam int TO = 16;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          wait_cyc;
    int          bdly;
    logic [31:0] prdata;
    bit          slverr;
  } txn_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    int          pen;
  } exp_t;

  typedef struct {
    txn_t t;
    exp_t e;
  } vec_t;

  typedef struct {
    int          done;
    int          hs_wr;
    int          hs_rd;
    int          lat;
    int          pen;
    int          overlap;
    int          unstable;
    int          resp_unstable;
    int          psel_seen;
    int          bvalid;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] rdata;
    logic        pwrite;
    logic [1:0]  resp;
  } obs_t;

  logic ACLK = 1'b0;
  logic ARESETn;
  int   n_checks = 0;
  int   n_errors = 0;

  axi_lite_apb_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Expected outcome from the protocol rules alone.
  function automatic exp_t model(input txn_t t);
    exp_t e;
    bit bad;
    bit to;
    bad     = (t.addr[1:0] != 2'b00) || (t.wr && t.strb != 4'hF);
    to      = t.wait_cyc >= TO;
    e.pen   = bad ? 0 : (to ? TO : t.wait_cyc + 1);
    e.lat   = bad ? 1 : e.pen + 2;
    e.resp  = (bad || to || t.slverr) ? 2'b10 : 2'b00;
    e.rdata = (!t.wr && !bad && !to) ? t.prdata : 32'h0;
    return e;
  endfunction

  // Called at a negedge with the bridge in IDLE; returns at a negedge in IDLE.
  task automatic run_txn(input txn_t t, output obs_t o);
    int hs;
    int vcnt;
    bit done;
    o.done = 0; o.hs_wr = 0; o.hs_rd = 0; o.lat = -1; o.pen = 0;
    o.overlap = 0; o.unstable = 0; o.resp_unstable = 0; o.psel_seen = 0;
    o.bvalid = 0; o.paddr = '0; o.pwdata = '0; o.rdata = '0; o.pwrite = 1'b0;
    o.resp = 2'b00;
    hs = -1; vcnt = 0; done = 0;
    if (t.wr) begin
      bus.AWADDR = t.addr; bus.WDATA = t.wdata; bus.WSTRB = t.strb;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    end else begin
      bus.ARADDR = t.addr; bus.ARVALID = 1'b1;
    end
    bus.PRDATA = t.prdata;
    bus.PSLVERR = t.slverr;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (bus.PSEL && bus.PENABLE) begin
        o.pen++;
        bus.PREADY = (o.pen > t.wait_cyc);
      end else begin
        bus.PREADY = 1'b0;
      end
      if (bus.PSEL) begin
        if (o.psel_seen == 0) begin
          o.psel_seen = 1; o.paddr = bus.PADDR; o.pwrite = bus.PWRITE; o.pwdata = bus.PWDATA;
        end else if (bus.PADDR !== o.paddr || bus.PWRITE !== o.pwrite || bus.PWDATA !== o.pwdata) begin
          o.unstable = 1;
        end
      end
      #1;
      if (bus.PSEL && (bus.AWREADY || bus.WREADY || bus.ARREADY)) o.overlap = 1;
      if (bus.AWREADY || bus.WREADY || bus.ARREADY) begin
        hs = cyc;
        o.hs_wr = int'(bus.AWREADY && bus.WREADY && !bus.ARREADY);
        o.hs_rd = int'(bus.ARREADY && !bus.AWREADY && !bus.WREADY);
      end
      if (bus.BVALID || bus.RVALID) begin
        if (vcnt == 0) begin
          o.lat = cyc - hs;
          o.bvalid = int'(bus.BVALID);
          o.resp = t.wr ? bus.BRESP : bus.RRESP;
          o.rdata = bus.RDATA;
        end else if ((t.wr ? bus.BRESP : bus.RRESP) !== o.resp || bus.RDATA !== o.rdata) begin
          o.resp_unstable = 1;
        end
        bus.BREADY = (vcnt >= t.bdly);
        bus.RREADY = (vcnt >= t.bdly);
        done = (vcnt >= t.bdly);
        vcnt++;
      end
      @(negedge ACLK);
      if (hs == cyc) begin
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      end
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    bus.BREADY = 1'b0; bus.RREADY = 1'b0; bus.PREADY = 1'b0;
    o.done = int'(done);
  endtask

  task automatic check_txn(input string tag, input txn_t t, input exp_t e, input obs_t o);
    chk({tag, " done"}, 32'(o.done), 32'd1);
    chk({tag, " channel"}, 32'(t.wr ? o.hs_wr : o.hs_rd), 32'd1);
    chk({tag, " resp_chan"}, 32'(o.bvalid), 32'(t.wr));
    chk({tag, " resp"}, 32'(o.resp), 32'(e.resp));
    chk({tag, " latency"}, o.lat, e.lat);
    chk({tag, " penable_cycles"}, o.pen, e.pen);
    chk({tag, " psel_overlap"}, 32'(o.overlap), 32'd0);
    chk({tag, " apb_stable"}, 32'(o.unstable), 32'd0);
    chk({tag, " resp_stable"}, 32'(o.resp_unstable), 32'd0);
    if (!t.wr) chk({tag, " rdata"}, o.rdata, e.rdata);
    if (e.pen > 0) begin
      chk({tag, " paddr"}, o.paddr, t.addr);
      chk({tag, " pwrite"}, 32'(o.pwrite), 32'(t.wr));
      if (t.wr) chk({tag, " pwdata"}, o.pwdata, t.wdata);
    end else begin
      chk({tag, " no_psel"}, 32'(o.psel_seen), 32'd0);
    end
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  vec_t  vecs [9];
  txn_t  t;
  exp_t  e;
  obs_t  o;
  int    order [$];
  int    apb_dir [$];
  int    nresp;
  bit    got_w;
  bit    got_r;
  bit    seen;

  initial begin
    vecs[0] = '{'{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 1'b0},        '{2'b00, 32'h0, 3, 1}};
    vecs[1] = '{'{1'b0, 32'h20, 32'h0, 4'hF, 3, 2, 32'h12345678, 1'b1},        '{2'b10, 32'h12345678, 6, 4}};
    vecs[2] = '{'{1'b1, 32'h14, 32'hCAFE0001, 4'h3, 0, 0, 32'h0, 1'b0},        '{2'b10, 32'h0, 1, 0}};
    vecs[3] = '{'{1'b0, 32'h22, 32'h0, 4'hF, 0, 1, 32'h11111111, 1'b0},        '{2'b10, 32'h0, 1, 0}};
    vecs[4] = '{'{1'b1, 32'h40, 32'h01020304, 4'hF, 100, 0, 32'h0, 1'b0},     '{2'b10, 32'h0, 18, 16}};
    vecs[5] = '{'{1'b1, 32'h44, 32'h0A0B0C0D, 4'hF, 0, 0, 32'h0, 1'b0},       '{2'b00, 32'h0, 3, 1}};
    vecs[6] = '{'{1'b0, 32'h30, 32'h0, 4'hF, 16, 0, 32'h77777777, 1'b0},       '{2'b10, 32'h0, 18, 16}};
    vecs[7] = '{'{1'b0, 32'h34, 32'h0, 4'hF, 15, 1, 32'hAA55AA55, 1'b0},       '{2'b00, 32'hAA55AA55, 18, 16}};
    vecs[8] = '{'{1'b1, 32'h3, 32'h5, 4'hF, 0, 0, 32'h0, 1'b0},                '{2'b10, 32'h0, 1, 0}};

    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    ARESETn = 1'b0;

    // Reset: all outputs low even with requests pending.
    repeat (2) @(negedge ACLK);
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1; bus.WSTRB = 4'hF;
    @(negedge ACLK);
    #1;
    chk("rst awready", 32'(bus.AWREADY), 32'd0);
    chk("rst wready", 32'(bus.WREADY), 32'd0);
    chk("rst arready", 32'(bus.ARREADY), 32'd0);
    chk("rst psel_penable", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 32'd0);
    chk("rst valids", 32'({bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP}), 32'd0);
    chk("rst paddr", bus.PADDR, 32'h0);
    chk("rst rdata", bus.RDATA, 32'h0);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].t, o);
      check_txn($sformatf("vec%0d", i), vecs[i].t, vecs[i].e, o);
    end

    for (int i = 0; i < 40; i++) begin
      t.wr = 1'($urandom_range(0, 1));
      t.addr = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) t.addr[1:0] = 2'($urandom_range(1, 3));
      t.wdata = $urandom;
      t.strb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      t.wait_cyc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      t.bdly = int'($urandom_range(0, 2));
      t.prdata = $urandom;
      t.slverr = 1'($urandom_range(0, 1));
      e = model(t);
      run_txn(t, o);
      check_txn($sformatf("rnd%0d", i), t, e, o);
    end

    // Arbitration: write and read pending together, twice; write wins each round.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      order.delete(); apb_dir.delete(); nresp = 0;
      bus.AWADDR = 32'h50; bus.WDATA = 32'h5555_0000 + 32'(r); bus.WSTRB = 4'hF;
      bus.ARADDR = 32'h54; bus.PRDATA = 32'h0BADF00D; bus.PSLVERR = 1'b0;
      bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
      bus.BREADY = 1'b1; bus.RREADY = 1'b1;
      for (int c = 0; c < 40 && nresp < 2; c++) begin
        bus.PREADY = bus.PSEL && bus.PENABLE;
        if (bus.PSEL && !bus.PENABLE) apb_dir.push_back(int'(bus.PWRITE));
        #1;
        got_w = bus.AWREADY && bus.WREADY;
        got_r = bus.ARREADY;
        if (got_w) order.push_back(1);
        if (got_r) order.push_back(0);
        if (bus.BVALID || bus.RVALID) nresp++;
        @(negedge ACLK);
        if (got_w) begin bus.AWVALID = 1'b0; bus.WVALID = 1'b0; end
        if (got_r) bus.ARVALID = 1'b0;
      end
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      bus.BREADY = 1'b0; bus.RREADY = 1'b0; bus.PREADY = 1'b0;
      chk($sformatf("arb%0d responses", r), nresp, 2);
      chk($sformatf("arb%0d accept_count", r), order.size(), 2);
      chk($sformatf("arb%0d apb_count", r), apb_dir.size(), 2);
      if (order.size() == 2) begin
        chk($sformatf("arb%0d first_is_write", r), order[0], 1);
        chk($sformatf("arb%0d second_is_read", r), order[1], 0);
      end
      if (apb_dir.size() == 2) begin
        chk($sformatf("arb%0d apb_first_write", r), apb_dir[0], 1);
        chk($sformatf("arb%0d apb_second_read", r), apb_dir[1], 0);
      end
    end

    // Reset asserted during ACCESS aborts the transfer.
    bus.AWADDR = 32'h60; bus.WDATA = 32'h6666_6666; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.PREADY = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge ACLK);
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      if (bus.PSEL && bus.PENABLE) seen = 1'b1;
    end
    chk("midrst reached_access", 32'(seen), 32'd1);
    ARESETn = 1'b0;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge ACLK);
    chk("midrst psel", 32'(bus.PSEL), 32'd0);
    chk("midrst penable", 32'(bus.PENABLE), 32'd0);
    chk("midrst bvalid", 32'(bus.BVALID), 32'd0);
    chk("midrst rvalid", 32'(bus.RVALID), 32'd0);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    ARESETn = 1'b1;
    @(negedge ACLK);
    t = '{1'b1, 32'h64, 32'h7777_8888, 4'hF, 1, 0, 32'h0, 1'b0};
    run_txn(t, o);
    check_txn("after_rst", t, model(t), o);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
